mc_control_unit: RTL and testbench

Parametrised multicycle control unit for the 16-bit, 4-bit-opcode core. It sequences fetch/decode/execute/memory/writeback, drives every datapath select and enable, and holds the architectural carry/zero flags for cz-conditional ALU instructions. Unlike the fixed single-cycle-memory controller, it supports variable-latency memory, either by a ready handshake or by a fixed wait-state counter. It also latches a sticky illegal-instruction flag.

---
 rtl/mc_control_unit.sv | 199 +++++++++++++++++++
 tb/tb_mc_control_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multicycle control unit for the 16-bit, 4-bit-opcode core: sequences the
// instruction phases, drives datapath selects/enables and holds the C/Z flags.
module mc_control_unit #(
  parameter bit USE_READY = 1'b1,
  parameter int MEM_WAIT  = 0,
  parameter int ALUCW     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic [1:0]       cz,
  input  logic             zero,
  input  logic             carry,
  input  logic             mem_ready,
  output logic             pcen,
  output logic             irwrite,
  output logic             regwrite,
  output logic             memwrite,
  output logic             alusrca,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [ALUCW-1:0] alucontrol,
  output logic             flag_c,
  output logic             flag_z,
  output logic             illegal,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_ADIEX  = 4'd8,  S_ADIWB  = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADI  = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_JMP  = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1100;
  localparam logic [3:0] WAIT_CNT = MEM_WAIT[3:0];

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg;
  logic       flag_c_reg, flag_z_reg, illegal_reg;
  logic       mem_done, mem_state, illegal_op, cond;
  logic [1:0] alu_sel;

  assign mem_done  = USE_READY ? mem_ready : (cnt_reg == WAIT_CNT);
  assign mem_state = (state_reg == S_FETCH) || (state_reg == S_MEMRD) ||
                     (state_reg == S_MEMWR);

  always_comb begin
    illegal_op = 1'b0;
    case (op)
      OP_ADD, OP_NAND: illegal_op = (cz == 2'b11);
      OP_ADI, OP_LW, OP_SW, OP_BEQ, OP_JMP: illegal_op = 1'b0;
      default: illegal_op = 1'b1;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (cz)
      2'b00: cond = 1'b1;
      2'b10: cond = flag_c_reg;
      2'b01: cond = flag_z_reg;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    pcen       = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alu_sel    = 2'd0;
    case (state_reg)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_done;
        pcen    = mem_done;
        if (mem_done) state_next = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        if (illegal_op) begin
          state_next = S_FETCH;
        end else begin
          case (op)
            OP_LW, OP_SW:    state_next = S_MEMADR;
            OP_ADD, OP_NAND: state_next = cond ? S_EXEC : S_FETCH;
            OP_ADI:          state_next = S_ADIEX;
            OP_BEQ:          state_next = S_BRANCH;
            OP_JMP:          state_next = S_JUMP;
            default:         state_next = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_done) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_done) state_next = S_FETCH;
      end
      S_EXEC: begin
        alusrca    = 1'b1;
        alu_sel    = (op == OP_NAND) ? 2'd2 : 2'd0;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        state_next = S_FETCH;
      end
      S_ADIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = S_ADIWB;
      end
      S_ADIWB: begin
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alu_sel    = 2'd1;
        pcsrc      = 2'b01;
        pcen       = zero;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        pcsrc      = 2'b10;
        pcen       = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // The wait counter restarts on every state change so each access is timed
  // from its own first cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_FETCH;
      cnt_reg     <= 4'd0;
      flag_c_reg  <= 1'b0;
      flag_z_reg  <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg) cnt_reg <= 4'd0;
      else if (mem_state)          cnt_reg <= cnt_reg + 4'd1;
      if (state_reg == S_DECODE && illegal_op) illegal_reg <= 1'b1;
      if (state_reg == S_EXEC) begin
        if (op == OP_ADD) begin
          flag_c_reg <= carry;
          flag_z_reg <= zero;
        end else if (op == OP_NAND) begin
          flag_z_reg <= zero;
        end
      end else if (state_reg == S_ADIEX) begin
        flag_c_reg <= carry;
        flag_z_reg <= zero;
      end
    end
  end

  assign alucontrol = ALUCW'(alu_sel);
  assign flag_c     = flag_c_reg;
  assign flag_z     = flag_z_reg;
  assign illegal    = illegal_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized bench for mc_control_unit: a ready-handshake instance and a
// two-wait-state instance run side by side against an instruction-level model.
module tb_mc_control_unit;

  logic       clk;
  logic       reset;
  logic [3:0] op_v    [2];
  logic [1:0] cz_v    [2];
  logic       zero_v  [2];
  logic       carry_v [2];
  logic       rdy_v   [2];
  logic [21:0] obs    [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst;
    logic flag_c, flag_z, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    mc_control_unit #(
      .USE_READY (gi == 0),
      .MEM_WAIT  ((gi == 0) ? 0 : 2),
      .ALUCW     (3)
    ) dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op_v[gi]),
      .cz         (cz_v[gi]),
      .zero       (zero_v[gi]),
      .carry      (carry_v[gi]),
      .mem_ready  (rdy_v[gi]),
      .pcen       (pcen),
      .irwrite    (irwrite),
      .regwrite   (regwrite),
      .memwrite   (memwrite),
      .alusrca    (alusrca),
      .iord       (iord),
      .memtoreg   (memtoreg),
      .regdst     (regdst),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .alucontrol (alucontrol),
      .flag_c     (flag_c),
      .flag_z     (flag_z),
      .illegal    (illegal),
      .state      (state)
    );

    assign obs[gi] = {state, pcen, irwrite, regwrite, memwrite, alusrca, iord,
                      memtoreg, regdst, alusrcb, pcsrc, alucontrol,
                      flag_c, flag_z, illegal};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Model: each instruction is expanded into its list of phases up front.
  int  m_plan [2][6];
  int  m_len  [2];
  int  m_idx  [2];
  int  m_cyc  [2];
  bit  m_c    [2];
  bit  m_z    [2];
  bit  m_ill  [2];
  bit  m_bad  [2];
  bit  m_done [2];
  logic [5:0] dq0 [$];
  logic [5:0] dq1 [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [21:0] expect_vec(int st, bit done, bit z, logic [3:0] op,
                                             bit cf, bit zf, bit ill);
    bit pcen, irw, rw, mw, asa, iord, m2r, rd;
    logic [1:0] asb, psrc;
    logic [2:0] aluc;
    pcen = (st == 0 && done) || (st == 10 && z) || (st == 11);
    irw  = (st == 0 && done);
    rw   = (st == 4) || (st == 7) || (st == 9);
    mw   = (st == 5);
    asa  = (st == 2) || (st == 6) || (st == 8) || (st == 10);
    iord = (st == 3) || (st == 5);
    m2r  = (st == 4);
    rd   = (st == 7);
    asb  = (st == 0) ? 2'b01 : (st == 1) ? 2'b11 : (st == 2 || st == 8) ? 2'b10 : 2'b00;
    psrc = (st == 10) ? 2'b01 : (st == 11) ? 2'b10 : 2'b00;
    aluc = (st == 10) ? 3'd1 : (st == 6 && op == 4'b0010) ? 3'd2 : 3'd0;
    return {4'(st), pcen, irw, rw, mw, asa, iord, m2r, rd, asb, psrc, aluc, cf, zf, ill};
  endfunction

  task automatic start_instr(input int i);
    logic [5:0] ins;
    logic [3:0] o;
    logic [1:0] c;
    bit cond;
    if (i == 0 && dq0.size() > 0)      ins = dq0.pop_front();
    else if (i == 1 && dq1.size() > 0) ins = dq1.pop_front();
    else if ($urandom_range(0, 3) == 0) ins = 6'($urandom_range(0, 63));
    else begin
      case ($urandom_range(0, 6))
        0: o = 4'b0000; 1: o = 4'b0010; 2: o = 4'b0001; 3: o = 4'b0100;
        4: o = 4'b0101; 5: o = 4'b1100; default: o = 4'b1001;
      endcase
      ins = {o, 2'($urandom_range(0, 3))};
    end
    o = ins[5:2];
    c = ins[1:0];
    op_v[i] = o;
    cz_v[i] = c;
    m_plan[i][0] = 0;
    m_plan[i][1] = 1;
    m_len[i] = 2;
    m_idx[i] = 0;
    m_cyc[i] = 0;
    m_bad[i] = 1'b0;
    cond = (c == 2'b00) || (c == 2'b10 && m_c[i]) || (c == 2'b01 && m_z[i]);
    case (o)
      4'b0000, 4'b0010: begin
        if (c == 2'b11) m_bad[i] = 1'b1;
        else if (cond) begin m_plan[i][2] = 6; m_plan[i][3] = 7; m_len[i] = 4; end
      end
      4'b0001: begin m_plan[i][2] = 8; m_plan[i][3] = 9; m_len[i] = 4; end
      4'b0100: begin m_plan[i][2] = 2; m_plan[i][3] = 3; m_plan[i][4] = 4; m_len[i] = 5; end
      4'b0101: begin m_plan[i][2] = 2; m_plan[i][3] = 5; m_len[i] = 4; end
      4'b1100: begin m_plan[i][2] = 10; m_len[i] = 3; end
      4'b1001: begin m_plan[i][2] = 11; m_len[i] = 3; end
      default: m_bad[i] = 1'b1;
    endcase
  endtask

  task automatic do_cycle(input bit rst_n);
    int st;
    logic [21:0] e;
    @(negedge clk);
    reset = rst_n;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_c[i] = 1'b0; m_z[i] = 1'b0; m_ill[i] = 1'b0; m_len[i] = 0;
      end
      if (m_len[i] == 0) start_instr(i);
      zero_v[i]  = 1'($urandom_range(0, 1));
      carry_v[i] = 1'($urandom_range(0, 1));
      rdy_v[i]   = ($urandom_range(0, 9) < 7);
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      st = m_plan[i][m_idx[i]];
      m_done[i] = (i == 0) ? rdy_v[0] : (m_cyc[1] == 2);
      e = expect_vec(st, m_done[i], zero_v[i], op_v[i], m_c[i], m_z[i], m_ill[i]);
      check($sformatf("state[%0d]", i), 32'(obs[i][21:18]), 32'(e[21:18]));
      check($sformatf("ctrl[%0d] st%0d", i, st), 32'(obs[i][17:3]), 32'(e[17:3]));
      check($sformatf("flags[%0d]", i), 32'(obs[i][2:0]), 32'(e[2:0]));
    end
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        st = m_plan[i][m_idx[i]];
        if (st == 1 && m_bad[i]) m_ill[i] = 1'b1;
        if (st == 6 && op_v[i] == 4'b0000) begin m_c[i] = carry_v[i]; m_z[i] = zero_v[i]; end
        if (st == 6 && op_v[i] == 4'b0010) m_z[i] = zero_v[i];
        if (st == 8) begin m_c[i] = carry_v[i]; m_z[i] = zero_v[i]; end
        if ((st == 0 || st == 3 || st == 5) && !m_done[i]) begin
          m_cyc[i]++;
        end else begin
          m_cyc[i] = 0;
          m_idx[i]++;
          if (m_idx[i] == m_len[i]) m_len[i] = 0;
        end
      end
    end
  endtask

  initial begin
    bit found;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op_v[i] = 4'd0; cz_v[i] = 2'd0; zero_v[i] = 1'b0; carry_v[i] = 1'b0; rdy_v[i] = 1'b1;
      m_len[i] = 0; m_idx[i] = 0; m_cyc[i] = 0;
      m_c[i] = 1'b0; m_z[i] = 1'b0; m_ill[i] = 1'b0; m_bad[i] = 1'b0;
    end
    dq0 = '{6'b0000_00, 6'b0000_10, 6'b0000_01, 6'b1111_00, 6'b0010_11,
            6'b1100_00, 6'b1100_00, 6'b1001_00, 6'b0100_00, 6'b0101_00, 6'b0001_00};
    dq1 = '{6'b0100_00, 6'b0101_00, 6'b0000_00, 6'b0010_10, 6'b1100_00, 6'b1001_00,
            6'b0001_00, 6'b0111_00};

    do_cycle(1'b0);
    do_cycle(1'b0);
    for (int n = 0; n < 3000; n++) do_cycle($urandom_range(0, 399) != 0);

    // Make the ready instance illegal, then pull reset in the middle of a store.
    dq0.push_back(6'b1111_00);
    dq0.push_back(6'b0101_00);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      do_cycle(1'b1);
      if (m_len[0] != 0 && m_plan[0][m_idx[0]] == 5 && m_ill[0]) found = 1'b1;
    end
    check("memwr_reached", 32'(found), 32'd1);
    if (found) begin
      do_cycle(1'b0);
      do_cycle(1'b0);
    end
    for (int n = 0; n < 200; n++) do_cycle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
